regfile_multiport_sb: RTL and testbench

- Parametrised successor to the single-cycle register file, intended for the pipelined MIPS datapath.
- Adds a configurable number of read ports, configurable width and depth, and an optional hardwired zero register.
- Adds a per-entry pending-write scoreboard and a sequenced bulk-clear engine with a busy/done handshake.
- Sits in the decode stage: hazard logic reads the pending flags, and writeback drives the write port.

---
 rtl/regfile_multiport_sb.sv | 109 ++++++++++
 tb/tb_regfile_multiport_sb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport_sb.sv
// Multi-port register file with a pending-write scoreboard and a sequenced bulk-clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and pending state to matching read ports.
module regfile_multiport_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic [NUM_READ*ADDR_W-1:0] ra,
  output logic [NUM_READ*DATA_W-1:0] rd,
  output logic [NUM_READ-1:0]        pend,
  input  logic                       mark_en,
  input  logic [ADDR_W-1:0]          mark_a,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pendbit;
  logic                wr_ok, mk_ok;
  logic [ADDR_W-1:0]   idx;

  // Writes and marks only land while idle, and never on the hardwired zero entry.
  assign wr_ok = (state == IDLE) && we && !((ZERO_REG != 0) && (wa == '0));
  assign mk_ok = (state == IDLE) && mark_en && !((ZERO_REG != 0) && (mark_a == '0));

  assign busy     = (state == CLEAR);
  assign clr_done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (cnt == CNT_MAX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  // The mark is applied after the write so a new producer supersedes the retiring one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendbit <= '0;
    end else if (state == CLEAR) begin
      pendbit[cnt] <= 1'b0;
    end else begin
      if (wr_ok) pendbit[wa]     <= 1'b0;
      if (mk_ok) pendbit[mark_a] <= 1'b1;
    end
  end

  always_comb begin
    rd   = '0;
    pend = '0;
    idx  = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      idx = ra[k*ADDR_W +: ADDR_W];
      rd[k*DATA_W +: DATA_W] = mem[idx];
      pend[k]                = pendbit[idx];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wa == idx)) begin
        rd[k*DATA_W +: DATA_W] = wd;
        pend[k]                = mk_ok && (mark_a == wa);
      end
`endif
      if ((ZERO_REG != 0) && (idx == '0)) begin
        rd[k*DATA_W +: DATA_W] = '0;
        pend[k]                = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Self-checking bench for regfile_multiport_sb: directed scenarios plus random traffic
// compared against an array-based reference model of the register file and clear engine.
module tb_regfile_multiport_sb;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_READ = 2;
  localparam int DEPTH    = 32;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       we;
  logic [ADDR_W-1:0]          wa;
  logic [DATA_W-1:0]          wd;
  logic [NUM_READ*ADDR_W-1:0] ra;
  logic [NUM_READ*DATA_W-1:0] rd;
  logic [NUM_READ-1:0]        pend;
  logic                       mark_en;
  logic [ADDR_W-1:0]          mark_a;
  logic                       clr_req;
  logic                       busy;
  logic                       clr_done;

  regfile_multiport_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd), .pend(pend),
    .mark_en(mark_en), .mark_a(mark_a), .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  // Reference model: contents, pending flags, clear progress and a pending done pulse.
  logic [DATA_W-1:0] refMem [DEPTH];
  bit                refPend [DEPTH];
  int                clearLeft;
  int                clearPos;
  bit                donePending;

  int total = 0;
  int bad   = 0;
  int busyCycles, doneCycles;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic bit modelIdle();
    return (clearLeft == 0) && !donePending;
  endfunction

  function automatic logic [DATA_W-1:0] expRd(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && modelIdle() && wa == a) return wd;
`endif
    return refMem[a];
  endfunction

  function automatic logic expPend(input logic [ADDR_W-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && modelIdle() && wa == a) return mark_en && (mark_a == wa);
`endif
    return refPend[a];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      refMem[i]  = '0;
      refPend[i] = 1'b0;
    end
    clearLeft   = 0;
    clearPos    = 0;
    donePending = 1'b0;
  endtask

  task automatic modelStep();
    if (donePending) begin
      donePending = 1'b0;
    end else if (clearLeft > 0) begin
      refMem[clearPos]  = '0;
      refPend[clearPos] = 1'b0;
      clearPos++;
      clearLeft--;
      if (clearLeft == 0) donePending = 1'b1;
    end else begin
      if (we && wa != 0) begin
        refMem[wa]  = wd;
        refPend[wa] = 1'b0;
      end
      if (mark_en && mark_a != 0) refPend[mark_a] = 1'b1;
      if (clr_req) begin
        clearLeft = DEPTH;
        clearPos  = 0;
      end
    end
  endtask

  task automatic checkAll(input string phase);
    for (int k = 0; k < NUM_READ; k++) begin
      checkOutput($sformatf("%s rd%0d", phase, k), rd[k*DATA_W +: DATA_W],
                  expRd(ra[k*ADDR_W +: ADDR_W]));
      checkOutput($sformatf("%s pend%0d", phase, k), {31'b0, pend[k]},
                  {31'b0, expPend(ra[k*ADDR_W +: ADDR_W])});
    end
    checkOutput($sformatf("%s busy", phase), {31'b0, busy}, {31'b0, clearLeft > 0});
    checkOutput($sformatf("%s clr_done", phase), {31'b0, clr_done}, {31'b0, donePending});
  endtask

  // Drive one cycle of inputs, check the combinational view, then advance the model.
  task automatic applyStimulus(input string phase, input bit iwe, input logic [ADDR_W-1:0] iwa,
                               input logic [DATA_W-1:0] iwd, input bit imk,
                               input logic [ADDR_W-1:0] ima, input bit iclr,
                               input logic [ADDR_W-1:0] ir0, input logic [ADDR_W-1:0] ir1);
    @(negedge clk);
    we = iwe; wa = iwa; wd = iwd; mark_en = imk; mark_a = ima; clr_req = iclr;
    ra = {ir1, ir0};
    #1;
    checkAll(phase);
    if (busy) busyCycles++;
    if (clr_done) doneCycles++;
    @(posedge clk);
    modelStep();
  endtask

  task automatic idleCycle(input string phase, input logic [ADDR_W-1:0] ir0,
                           input logic [ADDR_W-1:0] ir1);
    applyStimulus(phase, 1'b0, '0, '0, 1'b0, '0, 1'b0, ir0, ir1);
  endtask

  initial begin
    rst = 1'b1; we = 0; wa = 0; wd = 0; mark_en = 0; mark_a = 0; clr_req = 0; ra = '0;
    modelReset();
    repeat (2) @(negedge clk);
    ra = {5'd31, 5'd1};
    #1;
    checkAll("reset");
    rst = 1'b0;

    // Basic write then read, with port 1 on the zero register.
    applyStimulus("wr5", 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    idleCycle("rd5", 5, 0);
    checkOutput("rd5 const", rd[31:0], 32'hDEADBEEF);

    // Zero register ignores writes and marks.
    applyStimulus("wr0", 1, 0, 32'h1234, 0, 0, 0, 0, 5);
    applyStimulus("mk0", 0, 0, 0, 1, 0, 0, 0, 0);
    idleCycle("rd0", 0, 0);
    checkOutput("zero reg data", rd[31:0], 32'h0);

    // Scoreboard: mark, later retire, then write+mark together.
    applyStimulus("mk7", 0, 0, 0, 1, 7, 0, 7, 5);
    idleCycle("pend7", 7, 5);
    checkOutput("pend7 set", {31'b0, pend[0]}, 32'h1);
    idleCycle("pend7b", 5, 7);
    applyStimulus("wr7", 1, 7, 32'h77, 0, 0, 0, 7, 7);
    idleCycle("ret7", 7, 3);
    checkOutput("pend7 cleared", {31'b0, pend[0]}, 32'h0);
    applyStimulus("wrmk7", 1, 7, 32'h7777, 1, 7, 0, 7, 6);
    idleCycle("after wrmk7", 7, 6);
    checkOutput("wrmk7 pend", {31'b0, pend[0]}, 32'h1);
    checkOutput("wrmk7 data", rd[31:0], 32'h7777);
    applyStimulus("wr6mk8", 1, 6, 32'h66, 1, 8, 0, 6, 8);
    idleCycle("after wr6mk8", 6, 8);

    // Same-cycle write/read of entry 9 shows forwarding only when bypass is built in.
    applyStimulus("wr9 old", 1, 9, 32'h1111, 0, 0, 0, 9, 9);
    applyStimulus("wr9 byp", 1, 9, 32'hA5A5A5A5, 0, 0, 0, 9, 1);
`ifdef REGFILE_BYPASS_EN
    checkOutput("wr9 same cycle", rd[31:0], 32'hA5A5A5A5);
`else
    checkOutput("wr9 same cycle", rd[31:0], 32'h1111);
`endif
    idleCycle("wr9 next", 9, 1);
    checkOutput("wr9 next cycle", rd[31:0], 32'hA5A5A5A5);

    // Fill everything, clear, count busy/done, and try a dropped write mid-clear.
    for (int i = 1; i < DEPTH; i++)
      applyStimulus("fill", 1, i[4:0], 32'h100 + i, 1, i[4:0], 0, i[4:0], 5'(i - 1));
    busyCycles = 0; doneCycles = 0;
    applyStimulus("clrreq", 0, 0, 0, 0, 0, 1, 3, 20);
    for (int c = 0; c < 36; c++) begin
      if (c == 5) applyStimulus("drop wr3", 1, 3, 32'hBAD, 1, 4, 1, 3, 4);
      else        applyStimulus("clearing", 0, 0, 0, 0, 0, 0, 5'(c), 5'(31 - c));
    end
    checkOutput("busy length", busyCycles, 32);
    checkOutput("done pulses", doneCycles, 1);
    for (int i = 0; i < DEPTH; i += 2) idleCycle("swept", i[4:0], 5'(i + 1));
    checkOutput("addr3 after clear", rd[31:0] & 32'h0, 32'h0);
    idleCycle("addr3", 3, 4);
    checkOutput("dropped wr3", rd[31:0], 32'h0);

    // Refill, start a clear, and abort it with reset at clear cycle 10.
    for (int i = 1; i < DEPTH; i++)
      applyStimulus("refill", 1, i[4:0], 32'hC000 + i, 1, i[4:0], 0, i[4:0], 0);
    applyStimulus("clrreq2", 0, 0, 0, 0, 0, 1, 25, 20);
    for (int c = 0; c < 10; c++) idleCycle("clear2", 25, 20);
    checkOutput("pre-abort entry25", rd[31:0], 32'hC000 + 25);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    busyCycles = 0; doneCycles = 0;
    for (int i = 0; i < DEPTH; i += 2) begin
      ra = {5'(i + 1), i[4:0]};
      #1;
      checkAll("abort");
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) idleCycle("post abort", 5'(c), 5'(31 - c));
    checkOutput("abort busy", busyCycles, 0);
    checkOutput("abort done", doneCycles, 0);

    // Random traffic with hazards concentrated on a few addresses.
    for (int n = 0; n < 600; n++) begin
      applyStimulus("rand", 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom_range(0, 39) == 0,
                    5'($urandom_range(0, 7)), 5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
